multicycle_control: RTL

Multicycle MIPS control unit: a Moore/Mealy FSM that sequences the shared-ALU, shared-memory datapath over several cycles per instruction. It replaces single-cycle opcode decoding and keeps the same instruction set and branch/immediate encodings. It adds a memory ready handshake with a bounded wait and a sticky error state. It sits between the instruction register (opcode/rt/funct) and the datapath multiplexer, enable and ALU-control inputs.

---
 rtl/multicycle_control.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with bounded memory waits and sticky error.
// Optional: define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN to trap illegal encodings into ERROR.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [5:0]         i_opcode,
  input  logic [4:0]         i_rt,
  input  logic [5:0]         i_funct,
  input  logic               i_mem_ready,
  output logic               o_pcwrite,
  output logic               o_pcwritecond,
  output logic               o_iord,
  output logic               o_memread,
  output logic               o_memwrite,
  output logic               o_irwrite,
  output logic               o_regwrite,
  output logic               o_alusrca,
  output logic [1:0]         o_alusrcb,
  output logic [1:0]         o_aluop,
  output logic [1:0]         o_immedateop,
  output logic [2:0]         o_branch,
  output logic [1:0]         o_pcsource,
  output logic [1:0]         o_regdest,
  output logic [1:0]         o_memtoreg,
  output logic [STATE_W-1:0] o_state,
  output logic               o_error
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_ERROR   = 4'd15
  } state_t;

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  localparam state_t S_ILLEGAL = S_ERROR;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  state_t           r_state;
  state_t           w_next;
  state_t           w_dec_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_sw;
  logic [2:0]       r_branch;
  logic [1:0]       r_immop;
  logic [2:0]       w_dec_branch;
  logic [1:0]       w_dec_immop;
  logic             w_wait_state;
  logic             w_timeout;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout    = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Instruction decode; only consumed while in DECODE.
  always_comb begin
    w_dec_next   = S_ILLEGAL;
    w_dec_branch = 3'b000;
    w_dec_immop  = 2'b00;
    case (i_opcode)
      6'b000000: w_dec_next = (i_funct == 6'b001000) ? S_JR : S_REXEC;
      6'b100011,
      6'b101011: w_dec_next = S_MEMADDR;
      6'b000100: begin
        w_dec_next   = S_BRANCH;
        w_dec_branch = 3'b001;
      end
      6'b000101: begin
        w_dec_next   = S_BRANCH;
        w_dec_branch = 3'b010;
      end
      6'b000111: begin
        if (i_rt == 5'd0) begin
          w_dec_next   = S_BRANCH;
          w_dec_branch = 3'b011;
        end
      end
      6'b000001: begin
        if (i_rt == 5'd0) begin
          w_dec_next   = S_BRANCH;
          w_dec_branch = 3'b101;
        end else if (i_rt == 5'd1) begin
          w_dec_next   = S_BRANCH;
          w_dec_branch = 3'b100;
        end
      end
      6'b001000: begin
        w_dec_next  = S_IEXEC;
        w_dec_immop = 2'b01;
      end
      6'b001100: begin
        w_dec_next  = S_IEXEC;
        w_dec_immop = 2'b10;
      end
      6'b000010: w_dec_next = S_JUMP;
      6'b000011: w_dec_next = S_JAL;
      default:   w_dec_next = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_FETCH;
      r_cnt    <= '0;
      r_is_sw  <= 1'b0;
      r_branch <= 3'b000;
      r_immop  <= 2'b00;
    end else begin
      r_state <= w_next;
      // Counter restarts whenever the FSM moves, so each memory state gets a fresh budget.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait_state && !i_mem_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_DECODE) begin
        r_is_sw  <= (i_opcode == 6'b101011);
        r_branch <= w_dec_branch;
        r_immop  <= w_dec_immop;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    o_pcwrite     = 1'b0;
    o_pcwritecond = 1'b0;
    o_iord        = 1'b0;
    o_memread     = 1'b0;
    o_memwrite    = 1'b0;
    o_irwrite     = 1'b0;
    o_regwrite    = 1'b0;
    o_alusrca     = 1'b0;
    o_alusrcb     = 2'b00;
    o_aluop       = 2'b00;
    o_immedateop  = 2'b00;
    o_branch      = 3'b000;
    o_pcsource    = 2'b00;
    o_regdest     = 2'b00;
    o_memtoreg    = 2'b00;
    o_error       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
        if (i_mem_ready)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DECODE: begin
        o_alusrcb = 2'b11;
        w_next    = w_dec_next;
      end
      S_MEMADDR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next    = r_is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_memread = 1'b1;
        o_iord    = 1'b1;
        if (i_mem_ready)    w_next = S_MEMWB;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_MEMWB: begin
        o_regwrite = 1'b1;
        o_memtoreg = 2'b01;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        o_memwrite = 1'b1;
        o_iord     = 1'b1;
        if (i_mem_ready)    w_next = S_FETCH;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_REXEC: begin
        o_alusrca = 1'b1;
        o_aluop   = 2'b10;
        w_next    = S_RWB;
      end
      S_RWB: begin
        o_regwrite = 1'b1;
        o_regdest  = 2'b01;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        o_alusrca     = 1'b1;
        o_aluop       = 2'b01;
        o_pcwritecond = 1'b1;
        o_pcsource    = 2'b01;
        o_branch      = r_branch;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        o_pcwrite  = 1'b1;
        o_pcsource = 2'b10;
        w_next     = S_FETCH;
      end
      S_IEXEC: begin
        o_alusrca    = 1'b1;
        o_alusrcb    = 2'b10;
        o_aluop      = 2'b11;
        o_immedateop = r_immop;
        w_next       = S_IWB;
      end
      S_IWB: begin
        o_regwrite   = 1'b1;
        o_immedateop = r_immop;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        o_pcwrite  = 1'b1;
        o_pcsource = 2'b10;
        o_regwrite = 1'b1;
        o_regdest  = 2'b10;
        o_memtoreg = 2'b10;
        w_next     = S_FETCH;
      end
      S_JR: begin
        o_pcwrite  = 1'b1;
        o_pcsource = 2'b11;
        w_next     = S_FETCH;
      end
      S_ERROR: begin
        o_error = 1'b1;
        w_next  = S_ERROR;
      end
      default: w_next = S_FETCH;
    endcase
    // A reset cycle must never commit architectural state.
    if (i_reset) begin
      o_pcwrite     = 1'b0;
      o_pcwritecond = 1'b0;
      o_memwrite    = 1'b0;
      o_irwrite     = 1'b0;
      o_regwrite    = 1'b0;
    end
  end

  assign o_state = STATE_W'(r_state);

endmodule
